rk_tape_player: RTL and testbench



---
 rtl/rk_tape_player_pkg.sv | 15 +
 rtl/rk_tape_player_uart_rx.sv | 100 ++++++++++
 rtl/rk_tape_player.sv | 193 +++++++++++++++++++
 tb/tb_rk_tape_player.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rk_tape_player_pkg.sv
// rk_tape_pkg: shared types and constants for the Radio-86RK tape player.
//   rx_state_t  - UART receiver states
//   enc_state_t - phase encoder states
//   HALF_CYC_DEF, BAUD_DIV_DEF - defaults for a 50 MHz clock
//   CTS_MARGIN  - free FIFO slots kept when flow control is enabled
package rk_tape_pkg;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {IDLE, HALF1, HALF2} enc_state_t;

  localparam int HALF_CYC_DEF = 16667;  // 333 us half cell, 1500 bit/s
  localparam int BAUD_DIV_DEF = 434;    // 115200 baud
  localparam int CTS_MARGIN   = 4;

endpackage

// File: rtl/rk_tape_player_uart_rx.sv
// rk_uart_rx: 8N1 UART receiver with 2-FF input synchronizer.
// Ports:
//   CLK_50MHZ, reset (async, active-high), flush (sync abort to R_IDLE)
//   uart_rx  - asynchronous serial line, idle high
//   data     - received byte, valid while valid pulses
//   valid    - one-cycle pulse: byte received with good stop bit
//   ferr     - one-cycle pulse: stop bit sampled low, byte discarded
module rk_uart_rx
  import rk_tape_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       CLK_50MHZ,
  input  logic       reset,
  input  logic       flush,
  input  logic       uart_rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       ferr
);

  localparam logic [15:0] HALF_M1 = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(BAUD_DIV - 1);

  logic      rx_s1, rx_s2, rx_d;
  rx_state_t state;
  logic [15:0] cnt;
  logic [2:0]  bitn;
  logic        data_smp;

  assign data_smp = !flush && (state == R_DATA) && (cnt == FULL_M1);

  // Synchronizer and receiver control
  always_ff @(posedge CLK_50MHZ or posedge reset) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
      state <= R_IDLE;
      cnt   <= '0;
      bitn  <= '0;
      valid <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
      valid <= 1'b0;
      ferr  <= 1'b0;
      if (flush) begin
        state <= R_IDLE;
        cnt   <= '0;
        bitn  <= '0;
      end else begin
        case (state)
          R_IDLE: begin
            cnt <= '0;
            if (!rx_s2 && rx_d) state <= R_START;
          end
          R_START: begin
            if (cnt == HALF_M1) begin
              cnt  <= '0;
              bitn <= '0;
              // A high line at mid-start is a glitch, not a frame
              state <= rx_s2 ? R_IDLE : R_DATA;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          R_DATA: begin
            if (cnt == FULL_M1) begin
              cnt <= '0;
              if (bitn == 3'd7) state <= R_STOP;
              else              bitn  <= bitn + 3'd1;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          R_STOP: begin
            if (cnt == FULL_M1) begin
              cnt   <= '0;
              valid <= rx_s2;
              ferr  <= !rx_s2;
              state <= R_IDLE;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          default: state <= R_IDLE;
        endcase
      end
    end
  end

  // Data shift register, LSB arrives first
  always_ff @(posedge CLK_50MHZ) begin
    if (data_smp) data <= {rx_s2, data[7:1]};
  end

endmodule

// File: rtl/rk_tape_player.sv
// rk_tape_player: UART-fed byte FIFO driving a Radio-86RK phase-encoded
// tape waveform (to PPA1 PC4 tape-in).
// Ports:
//   CLK_50MHZ, reset (async, active-high)
//   uart_rx    - host serial input, 8N1
//   play       - level; start/continue playback while high
//   flush      - one-cycle pulse; empty FIFO, clear flags, abort playback
//   tape_out   - encoded waveform, each bit MSB-first as ~bit then bit
//   cts_n      - active-low clear-to-send
//   fifo_empty, busy, overrun (sticky), frame_err (sticky)
// Build option: define RK_TAPE_CTS_EN to raise cts_n when the FIFO holds
// FIFO_DEPTH-CTS_MARGIN or more bytes; otherwise cts_n is tied low.
module rk_tape_player
  import rk_tape_pkg::*;
#(
  parameter int HALF_CYC   = HALF_CYC_DEF,
  parameter int BAUD_DIV   = BAUD_DIV_DEF,
  parameter int FIFO_DEPTH = 16
) (
  input  logic CLK_50MHZ,
  input  logic reset,
  input  logic uart_rx,
  input  logic play,
  input  logic flush,
  output logic tape_out,
  output logic cts_n,
  output logic fifo_empty,
  output logic busy,
  output logic overrun,
  output logic frame_err
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);
  localparam logic [15:0] HC_M1   = 16'(HALF_CYC - 1);

  logic [7:0] rx_data;
  logic       rx_valid, rx_ferr;

  rk_uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .CLK_50MHZ (CLK_50MHZ),
    .reset     (reset),
    .flush     (flush),
    .uart_rx   (uart_rx),
    .data      (rx_data),
    .valid     (rx_valid),
    .ferr      (rx_ferr)
  );

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          full, push_ok, pop, shift;

  enc_state_t state;
  logic [7:0]  shreg;
  logic [2:0]  bitcnt;
  logic [15:0] tcnt;
  logic        hc_end;

  assign full    = (count == DEPTH_C);
  assign push_ok = !flush && rx_valid && (!full || pop);
  assign hc_end  = (tcnt == HC_M1);

  // Encoder step decisions: pop a new byte or shift to the next bit
  always_comb begin
    pop   = 1'b0;
    shift = 1'b0;
    if (!flush) begin
      case (state)
        IDLE:  pop = play && !fifo_empty;
        HALF2: if (hc_end) begin
          if (bitcnt != 3'd0) shift = 1'b1;
          else                pop   = play && !fifo_empty;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    count_nxt = count;
    if (flush) count_nxt = '0;
    else if (push_ok && !pop) count_nxt = count + 1'b1;
    else if (!push_ok && pop) count_nxt = count - 1'b1;
  end

  // FIFO control and sticky flags
  always_ff @(posedge CLK_50MHZ or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fifo_empty <= 1'b1;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      count      <= count_nxt;
      fifo_empty <= (count_nxt == '0);
      if (flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        if (rx_valid && full && !pop) overrun <= 1'b1;
        if (rx_ferr) frame_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (push_ok) mem[wr_ptr] <= rx_data;
  end

`ifdef RK_TAPE_CTS_EN
  localparam logic [AW:0] CTS_TH = (AW + 1)'(FIFO_DEPTH - CTS_MARGIN);

  always_ff @(posedge CLK_50MHZ or posedge reset) begin
    if (reset) cts_n <= 1'b0;
    else       cts_n <= (count_nxt >= CTS_TH);
  end
`else
  assign cts_n = 1'b0;
`endif

  // Encoder control; tape_out and busy trail the state by one cycle so
  // both stay aligned with each other
  always_ff @(posedge CLK_50MHZ or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bitcnt   <= '0;
      tcnt     <= '0;
      tape_out <= 1'b0;
      busy     <= 1'b0;
    end else if (flush) begin
      state    <= IDLE;
      bitcnt   <= '0;
      tcnt     <= '0;
      tape_out <= 1'b0;
      busy     <= 1'b0;
    end else begin
      busy <= (state != IDLE);
      case (state)
        HALF1:   tape_out <= ~shreg[7];
        HALF2:   tape_out <= shreg[7];
        default: ;
      endcase
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (pop) begin
            bitcnt <= 3'd7;
            state  <= HALF1;
          end
        end
        HALF1: begin
          if (hc_end) begin
            tcnt  <= '0;
            state <= HALF2;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        HALF2: begin
          if (hc_end) begin
            tcnt <= '0;
            if (shift) begin
              bitcnt <= bitcnt - 3'd1;
              state  <= HALF1;
            end else if (pop) begin
              bitcnt <= 3'd7;
              state  <= HALF1;
            end else begin
              state <= IDLE;
            end
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (pop)        shreg <= mem[rd_ptr];
    else if (shift) shreg <= {shreg[6:0], 1'b0};
  end

endmodule

// File: tb/tb_rk_tape_player.sv
// Self-checking bench for rk_tape_player (HALF_CYC=4, BAUD_DIV=8, FIFO_DEPTH=8).
module tb_rk_tape_player;

  localparam int HC = 4;
  localparam int BD = 8;
  localparam int FD = 8;

  logic CLK_50MHZ = 1'b0;
  logic reset = 1'b1;
  logic uart_rx = 1'b1;
  logic play = 1'b0;
  logic flush = 1'b0;
  logic tape_out, cts_n, fifo_empty, busy, overrun, frame_err;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int fall_cyc = 0;
  logic empty_q = 1'b1;
  logic [7:0] exp_q[$];

  rk_tape_player #(.HALF_CYC(HC), .BAUD_DIV(BD), .FIFO_DEPTH(FD)) dut (
    .CLK_50MHZ  (CLK_50MHZ),
    .reset      (reset),
    .uart_rx    (uart_rx),
    .play       (play),
    .flush      (flush),
    .tape_out   (tape_out),
    .cts_n      (cts_n),
    .fifo_empty (fifo_empty),
    .busy       (busy),
    .overrun    (overrun),
    .frame_err  (frame_err)
  );

  always #5 CLK_50MHZ = ~CLK_50MHZ;

  always @(posedge CLK_50MHZ) cyc <= cyc + 1;
  always @(negedge CLK_50MHZ) begin
    empty_q <= fifo_empty;
    if (empty_q && !fifo_empty) fall_cyc <= cyc;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  // Serial frame: start, 8 data LSB-first, stop bit as given, then idle
  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (BD) @(negedge CLK_50MHZ);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BD) @(negedge CLK_50MHZ);
    end
    uart_rx = stop;
    repeat (BD) @(negedge CLK_50MHZ);
    uart_rx = 1'b1;
    repeat (4) @(negedge CLK_50MHZ);
  endtask

  task automatic send_rand(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_byte(b, 1'b1);
    end
  endtask

  // Expected level at cycle i of a continuous playback of exp_q
  function automatic logic model_level(input int i);
    logic [7:0] b;
    logic bt;
    b  = exp_q[i / (16 * HC)];
    bt = b[7 - (i % (16 * HC)) / (2 * HC)];
    return ((i % (2 * HC)) < HC) ? ~bt : bt;
  endfunction

  task automatic wait_busy(output int lat);
    lat = 0;
    do begin
      @(negedge CLK_50MHZ);
      lat++;
    end while (!busy && lat < 20);
  endtask

  // Play n bytes from exp_q and compare the whole waveform
  task automatic play_check(input string tag, input int n, input bit drop);
    int lat, i, mism;
    logic [7:0] last;
    play = 1'b1;
    wait_busy(lat);
    chk({tag, "_start_lat"}, lat, 2);
    if (drop) play = 1'b0;
    i = 0;
    mism = 0;
    while (busy && i < 16 * HC * n + 16) begin
      if (i < 16 * HC * n && tape_out !== model_level(i)) mism++;
      i++;
      @(negedge CLK_50MHZ);
    end
    chk({tag, "_busy_len"}, i, 16 * HC * n);
    chk({tag, "_wave_mism"}, mism, 0);
    last = exp_q[n - 1];
    repeat (3) @(negedge CLK_50MHZ);
    chk({tag, "_idle_hold"}, int'(tape_out), int'(last[0]));
    play = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge CLK_50MHZ);
    flush = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    int lat, exp_cts;
    repeat (3) @(negedge CLK_50MHZ);
    chk("rst_tape_out", int'(tape_out), 0);
    chk("rst_cts_n", int'(cts_n), 0);
    chk("rst_fifo_empty", int'(fifo_empty), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    reset = 1'b0;
    repeat (3) @(negedge CLK_50MHZ);

    // Receive latency
    lat = cyc;
    send_byte(8'hA5, 1'b1);
    lat = fall_cyc - lat;
    chk("rx_latency_window", int'(lat >= 70 && lat <= 90), 1);
    chk("rx_fifo_empty", int'(fifo_empty), 0);
    chk("rx_frame_err", int'(frame_err), 0);
    do_flush();
    chk("flush_empty", int'(fifo_empty), 1);

    // Single byte 0x80
    exp_q.push_back(8'h80);
    send_byte(8'h80, 1'b1);
    play_check("enc80", 1, 1'b0);
    exp_q.delete();

    // Back-to-back 0x00, 0xE6
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hE6);
    send_byte(8'h00, 1'b1);
    send_byte(8'hE6, 1'b1);
    play_check("b2b", 2, 1'b0);
    exp_q.delete();

    // Random contiguous bytes
    send_rand(3);
    play_check("rand3", 3, 1'b0);
    exp_q.delete();

    // play dropped mid-byte: current byte completes, next one stays queued
    send_rand(2);
    play_check("drop", 1, 1'b1);
    chk("drop_fifo_kept", int'(fifo_empty), 0);
    do_flush();

    // Overrun and CTS threshold
    send_rand(3);
`ifdef RK_TAPE_CTS_EN
    exp_cts = 0;
`else
    exp_cts = 0;
`endif
    chk("cts_after3", int'(cts_n), exp_cts);
    send_rand(1);
`ifdef RK_TAPE_CTS_EN
    exp_cts = 1;
`else
    exp_cts = 0;
`endif
    chk("cts_after4", int'(cts_n), exp_cts);
    send_rand(4);
    chk("no_overrun_at_full", int'(overrun), 0);
    send_byte(8'($urandom), 1'b1);
    chk("overrun_set", int'(overrun), 1);
    play_check("full8", 8, 1'b0);
    chk("overrun_sticky", int'(overrun), 1);
    do_flush();
    chk("overrun_cleared", int'(overrun), 0);

    // Framing error and glitch reject
    send_byte(8'($urandom), 1'b0);
    chk("ferr_nothing_pushed", int'(fifo_empty), 1);
    chk("ferr_set", int'(frame_err), 1);
    do_flush();
    chk("ferr_cleared", int'(frame_err), 0);
    uart_rx = 1'b0;
    repeat (3) @(negedge CLK_50MHZ);
    uart_rx = 1'b1;
    repeat (100) @(negedge CLK_50MHZ);
    chk("glitch_nothing_pushed", int'(fifo_empty), 1);
    chk("glitch_no_ferr", int'(frame_err), 0);

    // Flush mid-cell
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    play = 1'b1;
    wait_busy(lat);
    @(negedge CLK_50MHZ);
    chk("pre_flush_level", int'(tape_out), 1);
    do_flush();
    chk("flush_tape_out", int'(tape_out), 0);
    chk("flush_busy", int'(busy), 0);
    chk("flush_fifo_empty", int'(fifo_empty), 1);
    chk("flush_flags", int'({overrun, frame_err}), 0);
    repeat (20) @(negedge CLK_50MHZ);
    chk("flush_stays_idle", int'(busy), 0);
    play = 1'b0;

    // Async reset mid-byte
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    play = 1'b1;
    wait_busy(lat);
    @(negedge CLK_50MHZ);
    #1 reset = 1'b1;
    #1;
    chk("areset_tape_out", int'(tape_out), 0);
    chk("areset_busy", int'(busy), 0);
    chk("areset_fifo_empty", int'(fifo_empty), 1);
    @(negedge CLK_50MHZ);
    reset = 1'b0;
    play = 1'b0;
    repeat (5) @(negedge CLK_50MHZ);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
